// File: rtl/twop_rf_param.sv
// ---------------------------------------------------------------------------
// twop_rf_param
//   Parametrised two-port register file: one synchronous write port and one
//   synchronous read port on a single clock. It adds an optional output
//   pipeline stage, read-during-write bypass, and a post-reset zero-fill
//   sequencer. The array is not usable until init_done_o rises.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   we_i         write enable
//   wr_addr_i    write address [AW-1:0]
//   wdata_i      write data [DW-1:0]
//   re_i         read enable
//   rd_addr_i    read address [AW-1:0]
//   ram_rdata_o  read data [DW-1:0]. It holds its last value between reads.
//   rvalid_o     one-cycle pulse that marks ram_rdata_o as valid
//   init_done_o  high once the array is usable
//   ram_ctrl     macro timing controls. The behavioural array ignores them.
//
// Handshake: there is no back-pressure. A read accepted at edge N
// (re_i=1 in READY) produces exactly one rvalid_o pulse at edge N+1, or
// at N+2 with OUT_REG=1. One read may be accepted every cycle.
// ---------------------------------------------------------------------------
module twop_rf_param #(
  parameter int DW            = 24,
  parameter int AW            = 8,
  parameter int DEPTH         = 2**AW,
  parameter int OUT_REG       = 0,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] ram_rdata_o,
  output logic          rvalid_o,
  output logic          init_done_o,
  input  logic [6:0]    ram_ctrl
);

  if (DEPTH < 2 || DEPTH > 2**AW) begin : g_bad_depth
    $fatal(1, "twop_rf_param: DEPTH=%0d is outside 2..2**AW", DEPTH);
  end

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_done_q;

  logic [DW-1:0] mem [DEPTH];

  logic          ready;
  logic          wr_fire;
  logic          rd_fire;
  logic          rd_in_range;
  logic [DW-1:0] r1_data_q, r1_data_d;
  logic          r1_valid_q;

  // The timing controls only matter to a hard macro dropped in place of this model.
  logic unused_ram_ctrl;
  assign unused_ram_ctrl = ^ram_ctrl;

  assign ready       = (state_q == ST_READY);
  assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_W);
  assign wr_fire     = ready & we_i & ({1'b0, wr_addr_i} < DEPTH_W);
  assign rd_fire     = ready & re_i;

  // Init sequencer: one zero write per cycle, then READY until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_READY;
      end
      ST_READY: ;
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  // The array itself is never reset. While rst is high it is left untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) mem[cnt_q] <= '0;
      else if (wr_fire)       mem[wr_addr_i] <= wdata_i;
    end
  end

  // Out-of-range reads return zero. A same-address collision either forwards
  // the incoming write data or returns the old word, depending on BYPASS.
  always_comb begin
    r1_data_d = mem[rd_addr_i];
    if (!rd_in_range)
      r1_data_d = '0;
    else if ((BYPASS != 0) && wr_fire && (wr_addr_i == rd_addr_i))
      r1_data_d = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid_q <= 1'b0;
      r1_data_q  <= '0;
    end else begin
      r1_valid_q <= rd_fire;
      if (rd_fire) r1_data_q <= r1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] r2_data_q;
    logic          r2_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        r2_valid_q <= 1'b0;
        r2_data_q  <= '0;
      end else begin
        r2_valid_q <= r1_valid_q;
        if (r1_valid_q) r2_data_q <= r1_data_q;
      end
    end

    assign ram_rdata_o = r2_data_q;
    assign rvalid_o    = r2_valid_q;
  end else begin : g_no_out_reg
    assign ram_rdata_o = r1_data_q;
    assign rvalid_o    = r1_valid_q;
  end

  assign init_done_o = init_done_q;

`ifndef SYNTHESIS
  a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
    ready |-> !$isunknown({we_i, re_i}))
    else $error("twop_rf_param: X on we_i/re_i while READY");
`endif

endmodule

// File: tb/tb_twop_rf_param.sv
// ---------------------------------------------------------------------------
// tb_twop_rf_param
//   Three DUT builds share one stimulus stream:
//     u0: DEPTH=256, OUT_REG=0, BYPASS=1, INIT_ON_RESET=1
//     u1: DEPTH=200, OUT_REG=1, BYPASS=0, INIT_ON_RESET=1
//     u2: DEPTH=256, INIT_ON_RESET=0 (only init_done_o timing is checked)
//   Inputs are driven 1 ns after each rising edge, and outputs are sampled
//   at that same point.
// ---------------------------------------------------------------------------
module tb_twop_rf_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [7:0]  wa;
  logic [23:0] wd;
  logic        re;
  logic [7:0]  ra;
  logic [6:0]  ram_ctrl;

  logic [23:0] rdata0, rdata1, rdata2;
  logic        rvalid0, rvalid1, rvalid2;
  logic        done0, done1, done2;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] exp0_q[$];
  logic [23:0] exp1_q[$];

  twop_rf_param #(.DW(24), .AW(8), .DEPTH(256), .OUT_REG(0), .BYPASS(1), .INIT_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .we_i(we), .wr_addr_i(wa), .wdata_i(wd), .re_i(re), .rd_addr_i(ra),
    .ram_rdata_o(rdata0), .rvalid_o(rvalid0), .init_done_o(done0), .ram_ctrl(ram_ctrl));

  twop_rf_param #(.DW(24), .AW(8), .DEPTH(200), .OUT_REG(1), .BYPASS(0), .INIT_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .we_i(we), .wr_addr_i(wa), .wdata_i(wd), .re_i(re), .rd_addr_i(ra),
    .ram_rdata_o(rdata1), .rvalid_o(rvalid1), .init_done_o(done1), .ram_ctrl(ram_ctrl));

  twop_rf_param #(.DW(24), .AW(8), .DEPTH(256), .OUT_REG(0), .BYPASS(1), .INIT_ON_RESET(0)) u2 (
    .clk(clk), .rst(rst), .we_i(we), .wr_addr_i(wa), .wdata_i(wd), .re_i(re), .rd_addr_i(ra),
    .ram_rdata_o(rdata2), .rvalid_o(rvalid2), .init_done_o(done2), .ram_ctrl(ram_ctrl));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] a, input logic [23:0] d,
                       input logic r, input logic [7:0] b);
    we = w; wa = a; wd = d; re = r; ra = b;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs cycles after rst falls and records the cycle on which each
  // init_done_o first reads high (-1 if it never does). With flood=1,
  // cycles 0..10 carry a write of 0xFFFFFF to address 5 plus a read of address 5.
  task automatic wait_init(input bit flood, output int r0, output int r1,
                           output int r2, output int rv_seen);
    int k;
    r0 = -1; r1 = -1; r2 = -1; rv_seen = 0; k = 0;
    while ((r0 < 0 || r1 < 0 || r2 < 0) && k < 400) begin
      if (flood && k < 11) drive(1'b1, 8'd5, 24'hFFFFFF, 1'b1, 8'd5);
      else                 drive(1'b0, 8'd0, 24'h0, 1'b0, 8'd0);
      cyc();
      k++;
      if (rvalid0 || rvalid1) rv_seen++;
      if (done0 && r0 < 0) r0 = k;
      if (done1 && r1 < 0) r1 = k;
      if (done2 && r2 < 0) r2 = k;
    end
    drive(1'b0, 8'd0, 24'h0, 1'b0, 8'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [23:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic        v0;
    logic [23:0] d0;
    logic        v1;
    logic [23:0] d1;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl[NV];

  function automatic vec_t mk(logic w, logic [7:0] a, logic [23:0] d, logic r, logic [7:0] b,
                              logic v0, logic [23:0] d0, logic v1, logic [23:0] d1);
    vec_t t;
    t.we = w; t.wa = a; t.wd = d; t.re = r; t.ra = b;
    t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1;
    return t;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int r0, r1, r2, rv;
    int bad;

    // Column order: we, wa, wd, re, ra | u0 valid/data (1-cycle) | u1 valid/data (2-cycle)
    // Reads just after init.
    tbl[0]  = mk(0, 8'h00, 24'h0,      1, 8'h00, 1, 24'h000000, 0, 24'h000000);
    tbl[1]  = mk(0, 8'h00, 24'h0,      1, 8'h80, 1, 24'h000000, 1, 24'h000000);
    tbl[2]  = mk(0, 8'h00, 24'h0,      1, 8'hFF, 1, 24'h000000, 1, 24'h000000);
    tbl[3]  = mk(0, 8'h00, 24'h0,      1, 8'h05, 1, 24'h000000, 1, 24'h000000);
    // Read latency.
    tbl[4]  = mk(1, 8'h10, 24'hA5A5A5, 0, 8'h00, 0, 24'h000000, 1, 24'h000000);
    tbl[5]  = mk(0, 8'h00, 24'h0,      1, 8'h10, 1, 24'hA5A5A5, 0, 24'h000000);
    tbl[6]  = mk(0, 8'h00, 24'h0,      0, 8'h00, 0, 24'hA5A5A5, 1, 24'hA5A5A5);
    tbl[7]  = mk(0, 8'h00, 24'h0,      0, 8'h00, 0, 24'hA5A5A5, 0, 24'hA5A5A5);
    // Streaming reads of 0x10..0x13.
    tbl[8]  = mk(1, 8'h11, 24'h123456, 0, 8'h00, 0, 24'hA5A5A5, 0, 24'hA5A5A5);
    tbl[9]  = mk(1, 8'h12, 24'h654321, 0, 8'h00, 0, 24'hA5A5A5, 0, 24'hA5A5A5);
    tbl[10] = mk(1, 8'h13, 24'h0F0F0F, 1, 8'h10, 1, 24'hA5A5A5, 0, 24'hA5A5A5);
    tbl[11] = mk(0, 8'h00, 24'h0,      1, 8'h11, 1, 24'h123456, 1, 24'hA5A5A5);
    tbl[12] = mk(0, 8'h00, 24'h0,      1, 8'h12, 1, 24'h654321, 1, 24'h123456);
    tbl[13] = mk(0, 8'h00, 24'h0,      1, 8'h13, 1, 24'h0F0F0F, 1, 24'h654321);
    tbl[14] = mk(0, 8'h00, 24'h0,      0, 8'h00, 0, 24'h0F0F0F, 1, 24'h0F0F0F);
    tbl[15] = mk(0, 8'h00, 24'h0,      0, 8'h00, 0, 24'h0F0F0F, 0, 24'h0F0F0F);
    // Collision at 0x20: u0 bypasses, u1 returns the old word.
    tbl[16] = mk(1, 8'h20, 24'h111111, 0, 8'h00, 0, 24'h0F0F0F, 0, 24'h0F0F0F);
    tbl[17] = mk(1, 8'h20, 24'h222222, 1, 8'h20, 1, 24'h222222, 0, 24'h0F0F0F);
    tbl[18] = mk(0, 8'h00, 24'h0,      1, 8'h20, 1, 24'h222222, 1, 24'h111111);
    tbl[19] = mk(0, 8'h00, 24'h0,      0, 8'h00, 0, 24'h222222, 1, 24'h222222);
    // Address 210 is in range for u0 and out of range for u1. Address 199 is valid in both.
    tbl[20] = mk(1, 8'hD2, 24'hABCDEF, 0, 8'h00, 0, 24'h222222, 0, 24'h222222);
    tbl[21] = mk(0, 8'h00, 24'h0,      1, 8'hD2, 1, 24'hABCDEF, 0, 24'h222222);
    tbl[22] = mk(1, 8'hC7, 24'h5A5A5A, 0, 8'h00, 0, 24'hABCDEF, 1, 24'h000000);
    tbl[23] = mk(0, 8'h00, 24'h0,      1, 8'hC7, 1, 24'h5A5A5A, 0, 24'h000000);
    tbl[24] = mk(0, 8'h00, 24'h0,      1, 8'hC7, 1, 24'h5A5A5A, 1, 24'h5A5A5A);
    tbl[25] = mk(0, 8'h00, 24'h0,      0, 8'h00, 0, 24'h5A5A5A, 1, 24'h5A5A5A);
    tbl[26] = mk(0, 8'h00, 24'h0,      0, 8'h00, 0, 24'h5A5A5A, 0, 24'h5A5A5A);

    // Reset state.
    ram_ctrl = 7'h2A;
    rst = 1'b1;
    drive(1'b0, 8'd0, 24'h0, 1'b0, 8'd0);
    repeat (3) cyc();
    check("reset rdata0", rdata0, 0);
    check("reset rvalid0", rvalid0, 0);
    check("reset done0", done0, 0);
    check("reset rdata1", rdata1, 0);
    check("reset rvalid1", rvalid1, 0);
    check("reset done1", done1, 0);
    check("reset done2", done2, 0);

    // Init fill, with traffic during cycles 0..10 that must be ignored.
    rst = 1'b0;
    wait_init(1'b1, r0, r1, r2, rv);
    check("init rise cycle u0", r0, 256);
    check("init rise cycle u1", r1, 200);
    check("init rise cycle u2 (no fill)", r2, 1);
    check("rvalid during init", rv, 0);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
      cyc();
      check($sformatf("vec%0d rvalid0", i), rvalid0, tbl[i].v0);
      check($sformatf("vec%0d rdata0", i), rdata0, tbl[i].d0);
      check($sformatf("vec%0d rvalid1", i), rvalid1, tbl[i].v1);
      check($sformatf("vec%0d rdata1", i), rdata1, tbl[i].d1);
    end
    check("done0 held", done0, 1);
    check("done1 held", done1, 1);

    // Reset while READY clears the pipeline registers.
    drive(1'b0, 8'd0, 24'h0, 1'b0, 8'd0);
    rst = 1'b1;
    repeat (2) cyc();
    check("re-reset rdata0", rdata0, 0);
    check("re-reset rdata1", rdata1, 0);
    check("re-reset done0", done0, 0);

    // Reset asserted at fill cycle 100 restarts the full fill.
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (done0 || done1 || rvalid0 || rvalid1) bad++;
    end
    check("mid-init outputs quiet", bad, 0);
    rst = 1'b1;
    repeat (2) cyc();
    check("mid-init reset done0", done0, 0);
    check("mid-init reset done1", done1, 0);
    rst = 1'b0;
    wait_init(1'b0, r0, r1, r2, rv);
    check("refill rise cycle u0", r0, 256);
    check("refill rise cycle u1", r1, 200);

    // Full-array readback, streamed back-to-back through the scoreboard.
    for (int a = 0; a < 256 + 3; a++) begin
      if (a < 256) begin
        drive(1'b0, 8'd0, 24'h0, 1'b1, 8'(a));
        exp0_q.push_back(24'h0);
        exp1_q.push_back(24'h0);
      end else begin
        drive(1'b0, 8'd0, 24'h0, 1'b0, 8'd0);
      end
      cyc();
      if (rvalid0) begin
        if (exp0_q.size() == 0) check("u0 unexpected rvalid", 1, 0);
        else check("u0 readback", rdata0, exp0_q.pop_front());
      end
      if (rvalid1) begin
        if (exp1_q.size() == 0) check("u1 unexpected rvalid", 1, 0);
        else check("u1 readback", rdata1, exp1_q.pop_front());
      end
    end
    check("u0 readback outstanding", exp0_q.size(), 0);
    check("u1 readback outstanding", exp1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/twop_rf_param.md
Name: twop_rf_param

Overview:
- Parametrised two-port register file: one synchronous write port, one synchronous read port, shared single clock.
- Next-generation replacement for the fixed-geometry two-port RF wrappers in the mem_wrappers area.
- Adds configurable width and depth, optional output pipeline register, and read-during-write bypass.
- Adds a post-reset hardware zero-initialisation sequencer and a read-valid indication, so clients never consume uninitialised data.

Parameters:
- DW, 24, data width in bits (1..128).
- AW, 8, address width in bits (1..12).
- DEPTH, 2**AW, number of words; must satisfy 2 <= DEPTH <= 2**AW.
- OUT_REG, 0, 1 adds an output register stage, raising read latency from 1 to 2.
- BYPASS, 1, 1 forwards write data on a same-cycle same-address read; 0 returns the old contents.
- INIT_ON_RESET, 1, 1 zero-fills the array after reset; 0 skips the fill.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we_i  in  1  write enable, active high.
- wr_addr_i  in  AW  write address.
- wdata_i  in  DW  write data.
- re_i  in  1  read enable, active high.
- rd_addr_i  in  AW  read address.
- ram_rdata_o  out  DW  read data.
- rvalid_o  out  1  one-cycle pulse; ram_rdata_o is valid in the same cycle.
- init_done_o  out  1  high once the array is usable.
- ram_ctrl  in  7  macro timing controls, bits [1:0] RTSEL, [3:2] WTSEL, [5:4] MTSEL, [6] reserved; no effect on the behavioural array, carried for macro-swap compatibility.

Behaviour:
- Reset, while rst=1:
  - ram_rdata_o=0, rvalid_o=0, init_done_o=0.
  - Pipeline registers are cleared.
  - FSM enters INIT if INIT_ON_RESET=1, otherwise READY.
  - Array contents are not reset directly.
- FSM states:
  - INIT: init counter starts at 0. Each cycle writes 0 to address cnt, then cnt increments. After writing DEPTH-1 the FSM moves to READY. The fill takes exactly DEPTH cycles after rst falls.
  - READY: normal operation; init_done_o=1. READY persists until the next reset.
- With INIT_ON_RESET=0, init_done_o rises in the first cycle after rst falls.
- During INIT:
  - we_i and re_i are ignored; writes are dropped.
  - No rvalid_o pulse is produced.
- Reset asserted mid-INIT restarts the fill from address 0 after rst falls.
- Write: when we_i=1 in READY, mem[wr_addr_i] <= wdata_i at the clock edge.
- Read with OUT_REG=0:
  - re_i=1 at edge N gives ram_rdata_o = mem[rd_addr_i] and rvalid_o=1 at edge N+1 (1-cycle latency).
- Read with OUT_REG=1:
  - Same result one cycle later (2-cycle latency).
  - The pipeline accepts one read per cycle with no bubbles.
- Hold: with no read in flight, ram_rdata_o keeps its last value and rvalid_o=0.
- Collision (we_i=re_i=1, wr_addr_i==rd_addr_i, same edge):
  - BYPASS=1: read returns wdata_i.
  - BYPASS=0: read returns the pre-write contents.
  - In both cases the write commits.
- Different-address simultaneous write and read: fully independent.
- Out-of-range addresses (address >= DEPTH, possible only when DEPTH < 2**AW):
  - Write is dropped.
  - Read returns 0, still with rvalid_o=1.
- Back-to-back reads to the same address return identical data unless that address is written in between.
- Verification-only checks (simulation, no synthesis impact):
  - X on we_i or re_i in READY flags an error.
  - DEPTH outside its legal range is a fatal error at elaboration.

Test Plan:
- Init fill: DW=24, AW=8, INIT_ON_RESET=1; release rst -> init_done_o=0 for exactly 256 cycles and rises on cycle 256; reads of addresses 0, 128 and 255 return 0x000000 with rvalid_o one cycle after re_i.
- Read latency: write 0xA5A5A5 to address 0x10, read 0x10 -> OUT_REG=0 gives data and rvalid_o at +1 cycle; OUT_REG=1 gives them at +2; streaming reads of 0x10..0x13 on consecutive cycles return 4 back-to-back valid words.
- Collision: mem[0x20]=0x111111; same edge writes 0x222222 to 0x20 and reads 0x20 -> BYPASS=1 returns 0x222222; BYPASS=0 returns 0x111111; a follow-up read returns 0x222222 in both builds.
- Ignored traffic during INIT: we_i=1 writing 0xFFFFFF to address 5 and re_i=1 during cycles 0..10 of the fill -> no rvalid_o; after init_done_o, a read of address 5 returns 0.
- Reset mid-INIT: assert rst at fill cycle 100 for 2 cycles -> init_done_o stays 0 for a further full 256 cycles; all addresses read 0 afterwards.
- Out-of-range access: DEPTH=200, AW=8; write 0xABCDEF to address 210, then read 210 -> returns 0 with rvalid_o=1; address 199 stays writable and readable.
